// File: rtl/gen_fifo_defines_pkg.sv
// Shared sizes and types for the function-generator LUT writer stage.
// The default widths match the adder's data_o and the generator FIFO word.
package gen_fifo_defines_pkg;

    localparam int DEF_LUT_ADDR   = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int QUEUE_DEPTH    = 4;
    localparam int LUT_DEPTH      = 2 ** DEF_LUT_ADDR;

    typedef logic [2:0]                occ_t;
    typedef logic [1:0]                qptr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] sample_t;

    // Up/down counter step; an increment and a decrement in one cycle cancel out.
    function automatic occ_t occ_update(occ_t value, logic inc, logic dec);
        return value + occ_t'(inc) - occ_t'(dec);
    endfunction

endpackage

// File: rtl/funct_generator_lut_rom.sv
// Synchronous-read waveform ROM; the registered output is pipeline stage S2.
// Without an init image, entry i holds i zero-extended/truncated to DATA_WIDTH.
module funct_generator_lut_rom #(
    parameter int    LUT_ADDR      = 8,
    parameter int    DATA_WIDTH    = 8,
    parameter string LUT_INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [LUT_ADDR-1:0]   addr,
    output logic [DATA_WIDTH-1:0] data_q
);

    logic [DATA_WIDTH-1:0] rom_word;

    assign rom_word = DATA_WIDTH'(addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else if (en) begin
            data_q <= rom_word;
        end
    end

endmodule

// File: rtl/funct_generator_lut_writer.sv
// LUT writer: registers the summed address (S1), reads the ROM (S2), queues samples and
// pushes them into the generator FIFO under credit-based valid/ready flow control.
module funct_generator_lut_writer
    import gen_fifo_defines_pkg::*;
#(
    parameter int    LUT_ADDR      = DEF_LUT_ADDR,
    parameter int    DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int    CNT_WIDTH     = 16,
    parameter string LUT_INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clrh_i,
    input  logic                  addr_vld_i,
    input  logic [LUT_ADDR-1:0]   addr_i,
    output logic                  ready_o,
    input  logic                  fifo_full_i,
    output logic                  wr_en_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic [CNT_WIDTH-1:0]  sample_cnt_o,
    output logic                  busy_o
);

    occ_t                  occ;
    occ_t                  q_cnt;
    logic                  s1_vld;
    logic                  s2_vld;
    logic [LUT_ADDR-1:0]   s1_addr;
    logic [DATA_WIDTH-1:0] s2_data;
    qptr_t                 wr_ptr;
    qptr_t                 rd_ptr;
    logic [DATA_WIDTH-1:0] q_mem [QUEUE_DEPTH];

    logic accept;
    logic q_empty;
    logic pop;
    logic push;

    // occ counts every sample from accept until write, so occ < 4 at accept reserves a queue slot.
    assign ready_o = rst && !clrh_i && (occ < occ_t'(QUEUE_DEPTH));
    assign accept  = addr_vld_i && ready_o;
    assign busy_o  = (occ != '0);

    // An empty queue lets the S2 sample go straight out, giving a two-cycle accept-to-write latency.
    assign q_empty   = (q_cnt == '0);
    assign wr_data_o = q_empty ? s2_data : q_mem[rd_ptr];
    assign wr_en_o   = (!q_empty || s2_vld) && !fifo_full_i && !clrh_i;
    assign pop       = wr_en_o && !q_empty;
    assign push      = s2_vld && !(wr_en_o && q_empty);

    funct_generator_lut_rom #(
        .LUT_ADDR     (LUT_ADDR),
        .DATA_WIDTH   (DATA_WIDTH),
        .LUT_INIT_FILE(LUT_INIT_FILE)
    ) u_rom (
        .clk   (clk),
        .rst   (rst),
        .en    (s1_vld),
        .addr  (s1_addr),
        .data_q(s2_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s1_addr <= '0;
        end else begin
            // NOTE: non-blocking assignments so s2_vld picks up the pre-edge s1_vld.
            s1_vld <= accept;
            s2_vld <= s1_vld && !clrh_i;
            if (accept) begin
                s1_addr <= addr_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
            // NOTE: the four queue words are reset so wr_data_o reads zero during reset;
            // a larger storage array would normally be left unreset.
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_mem[i] <= '0;
            end
        end else if (clrh_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (push) begin
                q_mem[wr_ptr] <= s2_data;
                wr_ptr        <= wr_ptr + qptr_t'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + qptr_t'(1);
            end
            q_cnt <= occ_update(q_cnt, push, pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ          <= '0;
            sample_cnt_o <= '0;
        end else if (clrh_i) begin
            occ          <= '0;
            sample_cnt_o <= '0;
        end else begin
            occ <= occ_update(occ, accept, wr_en_o);
            if (wr_en_o) begin
                sample_cnt_o <= sample_cnt_o + CNT_WIDTH'(1);
            end
        end
    end

endmodule
